// File: rtl/frame_stepper_if.sv
// rtl/frame_stepper_if.sv - control and frame-output bundle for frame_stepper
interface frame_stepper_if;
    logic [5:0] ani_sel;
    logic [5:0] limit;
    logic [2:0] speed;
    logic       pause;
    logic       step;
    logic       reverse;
    logic [5:0] ani_cur;
    logic [5:0] frame;
    logic       frame_stb;
    logic       wrap;

    modport master (
        output ani_sel, limit, speed, pause, step, reverse,
        input  ani_cur, frame, frame_stb, wrap
    );

    modport slave (
        input  ani_sel, limit, speed, pause, step, reverse,
        output ani_cur, frame, frame_stb, wrap
    );
endinterface

// File: rtl/frame_stepper.sv
// rtl/frame_stepper.sv - animation frame sequencer with prescaler, pause/step and reverse
module frame_stepper #(
    parameter int BASE_DIV = 8,
    parameter int PRE_W    = 24
) (
    input  logic           clk,
    input  logic           rst,
    frame_stepper_if.slave bus
);
    typedef enum logic [1:0] {LOAD, RUN, PAUSE} state_t;

    state_t           state, state_nx;
    logic [PRE_W-1:0] pre, pre_nx;
    logic [PRE_W-1:0] shifted, period;
    logic [5:0]       ani_q, ani_nx, frame_q, frame_nx;
    logic             stb_q, stb_nx, wrap_q, wrap_nx;
    logic [5:0]       adv_frame;
    logic             adv_wrap, adv, tick, change;

    localparam logic [PRE_W-1:0] BASE = BASE_DIV[PRE_W-1:0];

    assign shifted = BASE >> bus.speed;
    assign period  = (shifted == '0) ? {{(PRE_W-1){1'b0}}, 1'b1} : shifted;
    // >= so that a speed-up leaving pre past the new period still ticks at once
    assign tick    = (pre >= period - 1'b1);
    assign change  = (bus.ani_sel != ani_q);

    always_comb begin
        adv_frame = frame_q;
        adv_wrap  = 1'b0;
        if (bus.limit <= 6'd1) begin
            adv_frame = 6'd0;
            adv_wrap  = 1'b1;
        end else if (!bus.reverse) begin
            if (frame_q >= bus.limit - 6'd1) begin
                adv_frame = 6'd0;
                adv_wrap  = 1'b1;
            end else begin
                adv_frame = frame_q + 6'd1;
            end
        end else if (frame_q == 6'd0 || frame_q >= bus.limit) begin
            adv_frame = bus.limit - 6'd1;
            adv_wrap  = 1'b1;
        end else begin
            adv_frame = frame_q - 6'd1;
        end
    end

    always_comb begin
        state_nx = state;
        pre_nx   = '0;
        ani_nx   = ani_q;
        frame_nx = frame_q;
        stb_nx   = 1'b0;
        wrap_nx  = 1'b0;
        adv      = 1'b0;
        if (change) begin
            ani_nx   = bus.ani_sel;
            frame_nx = 6'd0;
            stb_nx   = 1'b1;
            state_nx = LOAD;
        end else begin
            case (state)
                LOAD:    state_nx = bus.pause ? PAUSE : RUN;
                RUN: begin
                    if (bus.pause) state_nx = PAUSE;
                    else if (tick) adv = 1'b1;
                    else           pre_nx = pre + 1'b1;
                end
                PAUSE: begin
                    if (!bus.pause) state_nx = RUN;
                    adv = bus.step;
                end
                default: state_nx = LOAD;
            endcase
            if (adv) begin
                frame_nx = adv_frame;
                stb_nx   = 1'b1;
                wrap_nx  = adv_wrap;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= LOAD;
            pre     <= '0;
            ani_q   <= 6'd0;
            frame_q <= 6'd0;
            stb_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            pre     <= pre_nx;
            ani_q   <= ani_nx;
            frame_q <= frame_nx;
            stb_q   <= stb_nx;
            wrap_q  <= wrap_nx;
        end
    end

    assign bus.ani_cur   = ani_q;
    assign bus.frame     = frame_q;
    assign bus.frame_stb = stb_q;
    assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_frame_stepper.sv
// tb/tb_frame_stepper.sv - randomized model-checked bench for frame_stepper
module tb_frame_stepper;
    localparam int BASE_DIV = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [5:0] lim_tab [0:63];

    frame_stepper_if bus ();

    frame_stepper #(.BASE_DIV(BASE_DIV), .PRE_W(24)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    assign bus.limit = lim_tab[bus.ani_cur];

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: mode 0 = loading, 1 = running, 2 = paused; cnt = cycles spent toward the next tick
    int   m_ani = 0, m_frame = 0, m_mode = 0, m_cnt = 0;
    logic m_stb = 1'b0, m_wrap = 1'b0;

    always @(posedge clk or posedge rst) begin
        int f, L, per, mode, cnt, fr, ani;
        bit st, wr, do_adv;
        if (rst) begin
            m_ani <= 0; m_frame <= 0; m_mode <= 0; m_cnt <= 0;
            m_stb <= 1'b0; m_wrap <= 1'b0;
        end else begin
            ani = m_ani; fr = m_frame; mode = m_mode; cnt = m_cnt;
            st = 0; wr = 0; do_adv = 0;
            per = BASE_DIV / (1 << bus.speed);
            if (per < 1) per = 1;
            if (int'(bus.ani_sel) != ani) begin
                ani = bus.ani_sel; fr = 0; st = 1; mode = 0; cnt = 0;
            end else if (mode == 0) begin
                mode = bus.pause ? 2 : 1; cnt = 0;
            end else if (mode == 1) begin
                if (bus.pause) begin mode = 2; cnt = 0; end
                else if (cnt + 1 >= per) begin do_adv = 1; cnt = 0; end
                else cnt = cnt + 1;
            end else begin
                do_adv = bus.step;
                if (!bus.pause) mode = 1;
                cnt = 0;
            end
            if (do_adv) begin
                L = bus.limit; f = fr; st = 1;
                if (L <= 1) begin fr = 0; wr = 1; end
                else if (!bus.reverse) begin
                    if (f + 1 >= L) begin fr = 0; wr = 1; end else fr = f + 1;
                end else begin
                    if (f == 0 || f >= L) begin fr = L - 1; wr = 1; end else fr = f - 1;
                end
            end
            m_ani <= ani; m_frame <= fr; m_mode <= mode; m_cnt <= cnt;
            m_stb <= st; m_wrap <= wr;
        end
    end

    always @(negedge clk) begin
        check("ani_cur", int'(bus.ani_cur), m_ani);
        check("frame", int'(bus.frame), m_frame);
        check("frame_stb", int'(bus.frame_stb), int'(m_stb));
        check("wrap", int'(bus.wrap), int'(m_wrap));
    end

    task automatic tick_in();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_stb(input int budget);
        bit got;
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (bus.frame_stb) got = 1;
        end
        if (!got) check("stb_timeout", 0, 1);
    endtask

    task automatic step_pulse();
        tick_in();
        bus.step = 1'b1;
        tick_in();
        bus.step = 1'b0;
    endtask

    initial begin
        int t_prev, t_now, exp_f;
        for (int i = 0; i < 64; i++) lim_tab[i] = 6'd10;
        bus.ani_sel = 0; bus.speed = 0; bus.pause = 0; bus.step = 0; bus.reverse = 0;
        repeat (3) tick_in();
        check("rst_frame", int'(bus.frame), 0);
        check("rst_ani", int'(bus.ani_cur), 0);
        check("rst_stb", int'(bus.frame_stb), 0);
        rst = 1'b0;

        // Forward loop of 10 frames, one advance per 8 cycles
        t_prev = 0;
        for (int i = 0; i < 11; i++) begin
            wait_stb(40);
            t_now = $time;
            exp_f = (i + 1) % 10;
            check("fwd_frame", int'(bus.frame), exp_f);
            check("fwd_wrap", int'(bus.wrap), (exp_f == 0) ? 1 : 0);
            if (i > 0) check("fwd_period", (t_now - t_prev) / 10, 8);
            t_prev = t_now;
        end

        // Reverse from a reload: 0 -> 5 (wrap) -> 4
        lim_tab[1] = 6'd6;
        tick_in();
        bus.reverse = 1; bus.ani_sel = 1;
        wait_stb(40);
        check("rev_reload", int'(bus.frame), 0);
        check("rev_reload_wrap", int'(bus.wrap), 0);
        wait_stb(40);
        check("rev_f5", int'(bus.frame), 5);
        check("rev_w5", int'(bus.wrap), 1);
        wait_stb(40);
        check("rev_f4", int'(bus.frame), 4);
        check("rev_w4", int'(bus.wrap), 0);

        // Paused stepping with limit 4
        lim_tab[3] = 6'd4;
        tick_in();
        bus.reverse = 0; bus.pause = 1; bus.ani_sel = 3;
        wait_stb(40);
        repeat (3) step_pulse();
        check("pause_f3", int'(bus.frame), 3);
        step_pulse();
        check("pause_f0", int'(bus.frame), 0);
        check("pause_w0", int'(bus.wrap), 1);
        step_pulse();
        check("pause_f1", int'(bus.frame), 1);
        check("pause_w1", int'(bus.wrap), 0);
        repeat (20) tick_in();
        check("pause_hold", int'(bus.frame), 1);

        // Degenerate limit 1, then a limit drop below the current frame
        lim_tab[4] = 6'd1;
        bus.pause = 0; bus.ani_sel = 4;
        wait_stb(40);
        for (int i = 0; i < 2; i++) begin
            wait_stb(40);
            check("deg_frame", int'(bus.frame), 0);
            check("deg_wrap", int'(bus.wrap), 1);
        end
        lim_tab[5] = 6'd8;
        tick_in();
        bus.ani_sel = 5;
        wait_stb(40);
        repeat (7) wait_stb(40);
        check("pre_drop_f7", int'(bus.frame), 7);
        lim_tab[5] = 6'd5;
        wait_stb(40);
        check("drop_frame", int'(bus.frame), 0);
        check("drop_wrap", int'(bus.wrap), 1);

        // Asynchronous reset mid-run at frame 6
        lim_tab[5] = 6'd10;
        repeat (6) wait_stb(40);
        check("pre_rst_f6", int'(bus.frame), 6);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_frame", int'(bus.frame), 0);
        check("async_ani", int'(bus.ani_cur), 0);
        tick_in();
        rst = 1'b0;
        wait_stb(40);
        check("post_rst_ani", int'(bus.ani_cur), 5);
        check("post_rst_f0", int'(bus.frame), 0);
        wait_stb(40);
        check("post_rst_f1", int'(bus.frame), 1);

        // Random traffic; the model compare process does the checking
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 4))
                0: lim_tab[i] = 6'($urandom_range(0, 1));
                1: lim_tab[i] = 6'd63;
                default: lim_tab[i] = 6'($urandom_range(2, 12));
            endcase
        end
        for (int c = 0; c < 5000; c++) begin
            tick_in();
            if ($urandom_range(0, 39) == 0) bus.ani_sel = 6'($urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) bus.speed = 3'($urandom);
            if ($urandom_range(0, 29) == 0) bus.pause = ~bus.pause;
            if ($urandom_range(0, 59) == 0) bus.reverse = ~bus.reverse;
            if ($urandom_range(0, 99) == 0) lim_tab[$urandom_range(0, 7)] = 6'($urandom_range(0, 63));
            bus.step = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 1499) == 0);
        end
        rst = 1'b0;
        repeat (4) tick_in();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/frame_stepper.md
FRAME_STEPPER -- requirements
Module: frame_stepper

Interface
REQ-001 Parameter BASE_DIV, default 8, is the prescaler base divisor in clk cycles per frame at speed 0.
REQ-002 Parameter PRE_W, default 24, is the prescaler counter width; BASE_DIV SHALL be less than 2^PRE_W.
REQ-003 clk  in  1  single system clock; all state SHALL change on the rising edge only.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 ani_sel  in  6  requested animation index.
REQ-006 limit  in  6  frame count of ani_cur, driven combinationally by the animation limit table.
REQ-007 speed  in  3  prescaler shift; period T = max(BASE_DIV >> speed, 1) cycles.
REQ-008 pause  in  1  level; hold the current frame.
REQ-009 step  in  1  one-cycle pulse; advance one frame while paused.
REQ-010 reverse  in  1  level; 1 = count down.
REQ-011 ani_cur  out  6  active animation index, registered; it drives the limit table.
REQ-012 frame  out  6  current frame index, registered.
REQ-013 frame_stb  out  1  one-cycle pulse in the cycle frame takes a new value (including reloads).
REQ-014 wrap  out  1  one-cycle pulse in the cycle frame wraps; it coincides with frame_stb.

Function
REQ-015 The FSM SHALL have the states LOAD, RUN and PAUSE.
REQ-016 The prescaler pre SHALL count 0..T-1 only in RUN; tick = (pre >= T-1); pre SHALL clear on tick.
REQ-017 A speed change that makes pre >= T-1 SHALL tick on the next RUN cycle.
REQ-018 pre SHALL be held at 0 in LOAD and PAUSE.
REQ-019 Change detect: in any state, ani_sel != ani_cur SHALL cause, next edge: ani_cur <= ani_sel, frame <= 0, pre <= 0, frame_stb = 1, wrap = 0, state <= LOAD.
REQ-020 Change detect SHALL take priority over tick, step and pause; a coincident tick or step SHALL be discarded.
REQ-021 LOAD SHALL last exactly one cycle with no advance, so that limit settles.
REQ-022 LOAD SHALL exit to PAUSE if pause = 1, else to RUN.
REQ-023 RUN -> PAUSE SHALL occur when pause = 1; a tick in the same cycle SHALL be discarded.
REQ-024 In RUN, advance SHALL occur on tick.
REQ-025 PAUSE -> RUN SHALL occur when pause = 0; pre starts at 0.
REQ-026 In PAUSE, each cycle with step = 1 SHALL advance one frame.
REQ-027 In RUN, step SHALL be ignored.
REQ-028 Advance, forward, with L = limit (6-bit unsigned, L=63 legal): frame >= L-1 -> 0 with wrap = 1; else frame + 1.
REQ-029 Advance, reverse: frame == 0 -> L-1 with wrap = 1; frame >= L -> L-1 with wrap = 1; else frame - 1.
REQ-030 Degenerate L = 0 or L = 1: frame SHALL be forced to 0, and every advance SHALL pulse frame_stb and wrap.
REQ-031 A reverse toggle SHALL take effect at the next advance without reloading frame.
REQ-032 frame_stb and wrap SHALL be 0 in every cycle without an advance or reload.

Reset
REQ-033 While rst = 1: ani_cur = 0, frame = 0, pre = 0, frame_stb = 0, wrap = 0, state = LOAD, with asynchronous effect.
REQ-034 After rst deasserts, the REQ-019 change detect SHALL apply on the first edge; if ani_sel = 0, LOAD SHALL exit normally.
REQ-035 rst asserted mid-sequence SHALL abort immediately; pulses in flight SHALL be dropped.

Verification
REQ-036 BASE_DIV = 8, speed = 0, ani_sel = 0, limit = 10 -> frame 0..9, one step per 8 cycles; at 9->0: frame_stb = 1 and wrap = 1 in the same cycle; 80 cycles per loop.
REQ-037 reverse = 1, limit = 6, frame = 0 at tick -> frame = 5, wrap = 1; next tick -> frame = 4, wrap = 0.
REQ-038 ani_cur = 2, frame = 4, ani_sel -> 16 coinciding with tick -> next edge: ani_cur = 16, frame = 0, frame_stb = 1, wrap = 0; no advance for 1 cycle; then RUN.
REQ-039 pause = 1, frame = 3, limit = 4, step pulses x2 -> frame 0 (wrap = 1), then 1; tick ignored while paused.
REQ-040 limit = 1 with frame = 0: each tick -> frame stays 0, frame_stb = wrap = 1; then limit -> 5 with frame = 7 forward -> 0, wrap = 1.
REQ-041 rst pulse mid-run with frame = 6 -> outputs 0 before the next clk edge; run resumes from frame 0 after LOAD.
